ref_bank_loader: RTL and testbench
==================================

REF_BANK_LOADER -- requirements
Module: ref_bank_loader

Interface
REQ-001 SHALL have parameter PIXEL, default 8, bits per pixel.
REQ-002 SHALL have parameter LANES, default 8, pixels per bank word.
REQ-003 SHALL have parameter DEPTH, default 128, words per bank; address width AW = 7.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to load one search-window bank.
REQ-007 SHALL have port src_valid  input  1  upstream word valid.
REQ-008 SHALL have port src_data  input  LANES*PIXEL  upstream pixel word.
REQ-009 SHALL have port src_ready  output  1  loader accepts word.
REQ-010 SHALL have port wr_en  output  1  bank write strobe.
REQ-011 SHALL have port Bank_sel  output  1  bank being written (0/1, ping-pong).
REQ-012 SHALL have port address  output  AW  bank write address.
REQ-013 SHALL have port ref_in  output  LANES*PIXEL  bank write data.
REQ-014 SHALL have port bank_release  input  2  consumer frees bank i (pulse).
REQ-015 SHALL have port bank_full  output  2  bank i holds a complete window.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse, bank load complete.
REQ-017 SHALL have port busy  output  1  high outside IDLE.

Function
REQ-018 SHALL implement FSM IDLE, WAIT_BANK, LOAD; reset state IDLE.
REQ-019 IDLE: start -> WAIT_BANK; start in any other state SHALL be ignored.
REQ-020 WAIT_BANK: when bank_full[ptr]==0 -> LOAD with word counter 0; else stall.
REQ-021 src_ready SHALL be 1 only in LOAD; handshake = src_valid & src_ready.
REQ-022 Each handshake SHALL register wr_en=1, address=counter, ref_in=src_data, Bank_sel=ptr in the next cycle (latency 1); wr_en=0 otherwise.
REQ-023 Counter SHALL increment per handshake; no handshake -> no write, counter holds.
REQ-024 Handshake at counter DEPTH-1 SHALL return FSM to IDLE; next cycle: last write, load_done=1, bank_full[ptr] set, ptr toggles.
REQ-025 bank_release[i] SHALL clear bank_full[i] next cycle; release of a non-full bank SHALL be ignored; set and release of same bank in one cycle SHALL leave it full.
REQ-026 Release of bank ptr while in WAIT_BANK SHALL allow LOAD entry the following cycle.
REQ-027 ref_in SHALL pass src_data bit-exact, lane order unchanged.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, ptr 0, counter 0, src_ready 0, wr_en 0, Bank_sel 0, address 0, ref_in 0, bank_full 2'b00, load_done 0, busy 0.
REQ-029 Reset mid-LOAD SHALL discard the partial load; the bank SHALL NOT be marked full.

Structure
REQ-030 PIXEL, LANES, DEPTH, AW and FSM state encoding SHALL reside in shared package me_pkg.
REQ-031 No sub-module; counter, ping-pong pointer and full flags SHALL be inline.

Verification
REQ-032 Reset, start, 128 back-to-back words 0x0F0F... -> writes at addresses 0..127 with Bank_sel=0, load_done 1 cycle after handshake 127, bank_full=01.
REQ-033 Second start -> Bank_sel=1, bank_full=11 afterwards; third start stalls in WAIT_BANK with src_ready=0 until bank_release=01, then loads bank 0.
REQ-034 src_valid toggled 1/0 every cycle with data 0x5555..., 0x3333... alternating -> address advances only on handshakes, data matches.
REQ-035 rst_n low after 40 words -> all outputs 0 immediately, bank_full=00; new start writes from address 0 on bank 0.
REQ-036 start while busy and bank_release to a non-full bank -> no effect on state, counter or bank_full.

Source files
------------

// File: rtl/me_pkg.sv
// Shared motion-estimation constants and the loader FSM encoding.
package me_pkg;

    // Bits per pixel.
    localparam int PIXEL = 8;
    // Pixels per bank word.
    localparam int LANES = 8;
    // Words per reference bank.
    localparam int DEPTH = 128;
    // Bank write address width.
    localparam int AW    = 7;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BANK = 2'd1,
        ST_LOAD      = 2'd2
    } loader_state_t;

    // One-hot mask selecting one of the two ping-pong banks.
    function automatic logic [1:0] bank_mask(input logic sel);
        bank_mask = sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ref_bank_loader.sv
// Streams one search-window bank (DEPTH words) from an upstream valid/ready
// source into one of two ping-pong reference banks and tracks which bank
// holds a complete window until the consumer releases it.
module ref_bank_loader #(
    parameter int PIXEL = me_pkg::PIXEL,
    parameter int LANES = me_pkg::LANES,
    parameter int DEPTH = me_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     src_valid,
    input  logic [LANES*PIXEL-1:0]   src_data,
    output logic                     src_ready,
    output logic                     wr_en,
    output logic                     Bank_sel,
    output logic [me_pkg::AW-1:0]    address,
    output logic [LANES*PIXEL-1:0]   ref_in,
    input  logic [1:0]               bank_release,
    output logic [1:0]               bank_full,
    output logic                     load_done,
    output logic                     busy
);

    import me_pkg::loader_state_t;
    import me_pkg::ST_IDLE;
    import me_pkg::ST_WAIT_BANK;
    import me_pkg::ST_LOAD;
    import me_pkg::bank_mask;

    localparam int AW = me_pkg::AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    loader_state_t   state;
    logic            ptr;
    logic [AW-1:0]   count;

    logic            handshake;
    logic            last_beat;
    logic [1:0]      fill_set;

    // Word transfer qualifiers and the bank that completes on this beat.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        handshake = src_valid & src_ready;
        last_beat = handshake && (count == LAST_ADDR);
        fill_set  = 2'b00;
        if (state == ST_LOAD && last_beat) begin
            fill_set = bank_mask(ptr);
        end
    end

    // FSM, word counter, ping-pong pointer, full flags and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            count     <= '0;
            src_ready <= 1'b0;
            wr_en     <= 1'b0;
            Bank_sel  <= 1'b0;
            address   <= '0;
            ref_in    <= '0;
            bank_full <= 2'b00;
            load_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;

            // A same-cycle set wins over a release of the same bank; releasing
            // an empty bank is a no-op by construction.
            bank_full <= (bank_full & ~bank_release) | fill_set;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WAIT_BANK;
                        busy  <= 1'b1;
                    end
                end

                ST_WAIT_BANK: begin
                    if (!bank_full[ptr]) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        src_ready <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (handshake) begin
                        wr_en    <= 1'b1;
                        address  <= count;
                        ref_in   <= src_data;
                        Bank_sel <= ptr;
                        if (last_beat) begin
                            state     <= ST_IDLE;
                            src_ready <= 1'b0;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                            ptr       <= ~ptr;
                            count     <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ref_bank_loader.sv
// Randomized scoreboard bench for ref_bank_loader: a driver issues stimulus
// and a behavioural model predicts writes and flag states; a negedge monitor
// compares every cycle.
module tb_ref_bank_loader;

    import me_pkg::*;

    localparam int DW = LANES * PIXEL;

    typedef struct {
        logic [AW-1:0] addr;
        logic          bank;
        logic [DW-1:0] data;
    } wr_item_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          wr_en;
    logic          Bank_sel;
    logic [AW-1:0] address;
    logic [DW-1:0] ref_in;
    logic [1:0]    bank_release;
    logic [1:0]    bank_full;
    logic          load_done;
    logic          busy;

    ref_bank_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .wr_en        (wr_en),
        .Bank_sel     (Bank_sel),
        .address      (address),
        .ref_in       (ref_in),
        .bank_release (bank_release),
        .bank_full    (bank_full),
        .load_done    (load_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: what phase the loader is in, how many words of the
    // current window have arrived, which bank is next, which banks are full.
    bit       m_waiting;
    bit       m_loading;
    int       m_words;
    int       m_bank;
    bit [1:0] m_full;
    bit       m_done;
    wr_item_t exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0;
        m_loading = 0;
        m_words   = 0;
        m_bank    = 0;
        m_full    = 2'b00;
        m_done    = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step(input bit st, input bit sv, input logic [DW-1:0] sd, input bit [1:0] rel);
        bit [1:0] newly_full;
        wr_item_t it;
        newly_full = 2'b00;
        m_done     = 0;
        if (m_loading) begin
            if (sv) begin
                it.addr = AW'(m_words);
                it.bank = m_bank[0];
                it.data = sd;
                exp_q.push_back(it);
                m_words++;
                if (m_words == DEPTH) begin
                    newly_full[m_bank] = 1'b1;
                    m_done    = 1;
                    m_loading = 0;
                    m_bank    = 1 - m_bank;
                end
            end
        end else if (m_waiting) begin
            if (!m_full[m_bank]) begin
                m_waiting = 0;
                m_loading = 1;
                m_words   = 0;
            end
        end else if (st) begin
            m_waiting = 1;
        end
        m_full = (m_full & ~rel) | newly_full;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(start, src_valid, src_data, bank_release);
        #2;
    endtask

    // Monitor: pops the scoreboard on every write and checks status outputs.
    initial begin
        wr_item_t it;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_src_ready", DW'(src_ready), '0);
                check("rst_wr_en",     DW'(wr_en),     '0);
                check("rst_bank_sel",  DW'(Bank_sel),  '0);
                check("rst_address",   DW'(address),   '0);
                check("rst_ref_in",    ref_in,         '0);
                check("rst_bank_full", DW'(bank_full), '0);
                check("rst_load_done", DW'(load_done), '0);
                check("rst_busy",      DW'(busy),      '0);
            end else begin
                check("src_ready", DW'(src_ready), DW'(m_loading));
                check("busy",      DW'(busy),      DW'(m_loading | m_waiting));
                check("bank_full", DW'(bank_full), DW'(m_full));
                check("load_done", DW'(load_done), DW'(m_done));
                if (wr_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", DW'(wr_en), '0);
                    end else begin
                        it = exp_q.pop_front();
                        check("address",  DW'(address),  DW'(it.addr));
                        check("bank_sel", DW'(Bank_sel), DW'(it.bank));
                        check("ref_in",   ref_in,        it.data);
                    end
                end else begin
                    check("missing_write", DW'(exp_q.size()), '0);
                end
            end
        end
    end

    // Issue a start and feed words until the window completes, the word limit
    // is hit, or the cycle budget runs out. mode 0: 0x0F back-to-back;
    // mode 1: valid toggling with 0x55/0x33 alternating; mode 2: random.
    task automatic run_load(input int mode, input int word_limit, input bit [1:0] rel_during);
        int cyc;
        bit phase;
        logic [7:0] pat;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        phase = 1'b0;
        while ((m_waiting || m_loading) && !(m_loading && m_words >= word_limit) && cyc < 3000) begin
            case (mode)
                0: begin
                    src_valid = 1'b1;
                    src_data  = {LANES{8'h0F}};
                end
                1: begin
                    pat       = phase ? 8'h33 : 8'h55;
                    src_valid = phase;
                    src_data  = {LANES{pat}};
                    phase     = ~phase;
                end
                default: begin
                    src_valid = 1'($urandom_range(0, 3) != 0);
                    src_data  = {$urandom, $urandom};
                end
            endcase
            // Sprinkle ignored requests: start while busy, optional releases.
            start        = 1'($urandom_range(0, 15) == 0);
            bank_release = ($urandom_range(0, 31) == 0) ? rel_during : 2'b00;
            tick();
            cyc++;
        end
        start        = 1'b0;
        src_valid    = 1'b0;
        bank_release = 2'b00;
        if (cyc >= 3000) check("load_timeout", DW'(cyc), '0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        src_valid    = 1'b0;
        src_data     = '0;
        bank_release = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Bank 0: back-to-back constant pattern.
        run_load(0, DEPTH, 2'b00);
        repeat (2) tick();

        // Bank 1: random data and valid.
        run_load(2, DEPTH, 2'b00);
        repeat (2) tick();

        // Third start stalls with both banks full, then bank 0 is released.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        bank_release = 2'b01;
        tick();
        bank_release = 2'b00;
        // Toggling valid; bank 0 releases while loading it are ignored.
        run_load(1, DEPTH, 2'b01);
        repeat (2) tick();

        // Free both banks, then reset in the middle of a load.
        bank_release = 2'b11;
        tick();
        bank_release = 2'b00;
        tick();
        run_load(2, 40, 2'b00);
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Fresh load after reset lands on bank 0 from address 0.
        run_load(2, DEPTH, 2'b10);
        repeat (3) tick();
        check("queue_drained", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
